// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for a 5-stage RV32I pipeline.
//
// It merges the load-use kill, EX-stage branch redirects and the instruction
// and data memory ready signals into per-register enables and flushes. A
// three-state FSM (RUN / DWAIT / FAULT) tracks multi-cycle data-memory waits,
// and a watchdog traps into FAULT when a wait runs too long. Stall and
// redirect events are counted in saturating counters.
//
// Parameters:
//   DMEM_TIMEOUT  max consecutive DWAIT cycles before FAULT (1..255)
//   CNT_W         width of the performance counters
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   load_use_i            ID depends on a load currently in EX
//   branch_taken_i        EX-stage branch/jump resolved taken
//   imem_ready_i          fetch data valid this cycle
//   dmem_req_i            MEM-stage instruction is a load/store
//   dmem_ready_i          data memory completes the access this cycle
//   pc_en_o, pc_sel_o     PC update enable, 1 = branch target
//   *_en_o                pipeline register enables
//   *_flush_o             load a NOP bubble (overrides the enable)
//   mem_fault_o           sticky watchdog fault
//   stall_cnt_o           cycles with pc_en_o = 0, saturating
//   flush_cnt_o           taken redirects, saturating
module pipeline_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             pc_sel_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_flush_o,
  output logic             mem_fault_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Value of wait_cnt on the last DWAIT cycle allowed before the trap.
  localparam logic [7:0] WAIT_LAST = 8'(DMEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dstall;
  logic mem_hold;

  assign dstall = dmem_req_i && !dmem_ready_i;

  // In DWAIT the access is already known to be outstanding, so only the
  // ready handshake decides whether this cycle is still a hold cycle.
  always_comb begin
    mem_hold = 1'b0;
    case (state_q)
      ST_RUN:   mem_hold = dstall;
      ST_DWAIT: mem_hold = !dmem_ready_i;
      default:  mem_hold = 1'b0;
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    wait_d        = wait_q;
    pc_en_o       = 1'b1;
    pc_sel_o      = 1'b0;
    ifid_en_o     = 1'b1;
    idex_en_o     = 1'b1;
    exmem_en_o    = 1'b1;
    memwb_en_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    memwb_flush_o = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dstall) begin
          state_d = ST_DWAIT;
          wait_d  = 8'd0;
        end
      end
      ST_DWAIT: begin
        if (dmem_ready_i) begin
          state_d = ST_RUN;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ST_FAULT;
    endcase

    if (state_q == ST_FAULT) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
      memwb_en_o = 1'b0;
    end else if (mem_hold) begin
      // Freeze everything up to EX/MEM; WB receives bubbles while the
      // access is outstanding.
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_flush_o = 1'b1;
    end else if (branch_taken_i) begin
      // Younger instructions in IF/ID and ID/EX are wrong-path, so any
      // load-use or fetch stall they raise is moot.
      pc_sel_o     = 1'b1;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use_i) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end else if (!imem_ready_i) begin
      pc_en_o      = 1'b0;
      ifid_flush_o = 1'b1;
    end

    if (rst_i) begin
      state_d       = ST_RUN;
      wait_d        = 8'd0;
      pc_en_o       = 1'b0;
      pc_sel_o      = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_en_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      memwb_flush_o = 1'b1;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst_i && !pc_en_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (pc_en_o && pc_sel_o && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_q      <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_fault_o = (state_q == ST_FAULT);
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the Chronos RV32I 5-stage pipeline (IF/ID/EX/MEM/WB). It merges the load-use kill from hazard detection, EX-stage branch/jump redirects, and instruction/data memory ready handshakes into per-register enable and flush controls. It tracks multi-cycle data-memory waits with an FSM and timeout watchdog, and keeps stall/flush performance counters. It sits beside the hazard detection unit and drives the PC and every pipeline register.

## Interface
- DMEM_TIMEOUT, 64: max consecutive DWAIT cycles before fault (range 1..255)
- CNT_W, 32: width of performance counters
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- load_use  in  1  load-use kill from hazard detection (ID depends on a load in EX)
- branch_taken  in  1  EX-stage branch/jump resolved taken
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM-stage instruction is a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register update enable
- pc_sel  out  1  1 = load branch target, 0 = PC+4
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load NOP bubble into that register (flush overrides enable)
- mem_fault  out  1  sticky, DMEM_TIMEOUT exceeded
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
- flush_cnt  out  CNT_W  taken redirects, saturating

## Operation
- FSM states: RUN, DWAIT, FAULT. Reset goes to RUN.
- dstall = dmem_req && !dmem_ready.
- RUN: the first matching rule wins.
  - dstall: go to DWAIT. Set pc_en, ifid_en, idex_en, exmem_en = 0 and memwb_flush = 1. Branch, load_use and imem are ignored.
  - branch_taken: pc_en=1, pc_sel=1, ifid_flush=1, idex_flush=1, all other enables 1. The load_use and imem stalls are overridden because their instructions are wrong-path.
  - load_use: pc_en=0, ifid_en=0, idex_flush=1. exmem_en and memwb_en stay 1.
  - !imem_ready: pc_en=0, ifid_flush=1. All downstream registers advance.
  - Otherwise: all enables 1, all flushes 0, pc_sel=0.
- DWAIT:
  - Outputs match the dstall row.
  - wait_cnt (8 bit) increments each cycle.
  - dmem_ready=1: go to RUN. This cycle applies the RUN rules with dstall=0, so all registers advance or follow the branch/load_use/imem rules.
  - wait_cnt == DMEM_TIMEOUT-1 with dmem_ready=0: go to FAULT.
  - wait_cnt clears on entry to DWAIT.
- FAULT:
  - All enables 0, all flushes 0.
  - mem_fault=1.
  - Held until rst.
- stall_cnt increments on any cycle with pc_en=0 and not in reset, including FAULT. It saturates at all-ones.
- flush_cnt increments when pc_sel=1 and pc_en=1. It saturates at all-ones.

## Timing
- All control outputs are combinational from the current state and inputs, valid in the same cycle.
- State, wait_cnt, counters and mem_fault update on the rising edge of clk.
- Reset value of every output:
  - While rst=1: all *_en = 0, ifid_flush = idex_flush = memwb_flush = 1, pc_sel = 0.
  - Next cycle: mem_fault = 0, stall_cnt = flush_cnt = 0, state RUN, wait_cnt = 0.
- Reset mid-DWAIT or in FAULT returns to RUN on the next edge. The memory side must drop dmem_req during reset.
- Load-use penalty: exactly 1 bubble per load_use cycle. The hazard unit deasserts load_use the cycle after the bubble.
- Branch penalty: 2 bubbles (IF/ID and ID/EX). The redirect happens in the same cycle as branch_taken.
- A data access with ready on the first cycle costs 0 stall cycles.
- An access with N not-ready cycles costs N stall cycles and N WB bubbles.
- A branch_taken held in EX during DWAIT is honoured on the release cycle. This works because EX is frozen, so the EX/MEM contents and branch inputs are stable.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 with all inputs idle and imem_ready=1. Required: during reset all enables 0 and flushes 1. After release: all enables 1, all flushes 0, stall_cnt=0, flush_cnt=0.
- Load-use: load_use=1 for 1 cycle. Required: that cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. The next cycle returns to normal. stall_cnt=1.
- Branch vs load-use: branch_taken=1 and load_use=1 together. Required: pc_en=1, pc_sel=1, ifid_flush=1, idex_flush=1. flush_cnt=1, stall_cnt unchanged.
- Data-memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1.
  - Required: 3 cycles with pc_en=exmem_en=0 and memwb_flush=1. The 4th cycle advances.
  - State sequence RUN→DWAIT→DWAIT→DWAIT→RUN; stall_cnt=3.
  - Repeat with branch_taken=1 held throughout: pc_sel=1 appears only on the release cycle.
- Timeout: DMEM_TIMEOUT=4, dmem_ready held at 0.
  - Required: FAULT entered after 4 DWAIT cycles; mem_fault=1 with all enables 0, held.
  - rst clears mem_fault and returns the FSM to RUN.
- Saturation: CNT_W=4, hold imem_ready=0 for 20 cycles. Required: stall_cnt stops at 15; ifid_flush=1 every cycle.
